// File: rtl/pe_ctx_loop.sv
// Context-driven processing element: steps through a context memory, one
// context per cycle, repeated for a programmable number of passes.
`timescale 1ns/1ps

module pe_ctx_loop #(
    parameter int DATA_W    = 32,
    parameter int CTX_DEPTH = 16,
    parameter int NPORT     = 4,
    parameter int NREG      = 8,
    localparam int AW       = $clog2(CTX_DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [31:0]             cfg_data,
    input  logic                    start,
    input  logic [AW:0]             ctx_len,
    input  logic [7:0]              loop_cnt,
    input  logic [NPORT*DATA_W-1:0] in_data,
    input  logic [NPORT-1:0]        in_pred,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_pred,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [AW-1:0]     cp;
    logic [7:0]        pass;
    logic [7:0]        loops;
    logic [AW:0]       len;
    logic [AW:0]       len_clamped;
    logic              cp_last;

    logic [28:0]       ctx_mem [CTX_DEPTH];
    logic [28:0]       ctx;
    logic [DATA_W-1:0] regs [NREG];
    logic              p;

    logic [3:0]        op;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [2:0]        dst;
    logic              wr;
    logic              oe;
    logic              pguard;
    logic [2:0]        psrc;
    logic [7:0]        imm;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] result;
    logic              is_cmp;
    logic              is_nop;
    logic              cmp;
    logic              pred_hit;
    logic              pred_val;
    logic              p_next;
    logic              exec;
    logic              unused_cfg;

    // The top three context bits carry no meaning and are never stored.
    assign unused_cfg = ^cfg_data[31:29];

    assign ctx    = ctx_mem[cp];
    assign op     = ctx[3:0];
    assign src_a  = ctx[7:4];
    assign src_b  = ctx[11:8];
    assign dst    = ctx[14:12];
    assign wr     = ctx[15];
    assign oe     = ctx[16];
    assign pguard = ctx[17];
    assign psrc   = ctx[20:18];
    assign imm    = ctx[28:21];
    assign imm_ext = DATA_W'($signed(imm));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign len_clamped = (ctx_len > (AW+1)'(CTX_DEPTH)) ? (AW+1)'(CTX_DEPTH) : ctx_len;
    assign cp_last     = ({1'b0, cp} == len - (AW+1)'(1));

    always_comb begin
        a_val = '0;
        b_val = '0;
        for (int k = 0; k < NREG; k++) begin
            if (src_a == 4'(k)) a_val = regs[k];
            if (src_b == 4'(k)) b_val = regs[k];
        end
        for (int k = 0; k < NPORT; k++) begin
            if (src_a == 4'(k + 8)) a_val = in_data[k*DATA_W +: DATA_W];
            if (src_b == 4'(k + 8)) b_val = in_data[k*DATA_W +: DATA_W];
        end
        if (src_a == 4'd15) a_val = imm_ext;
        if (src_b == 4'd15) b_val = imm_ext;
    end

    always_comb begin
        result = '0;
        is_cmp = 1'b0;
        is_nop = 1'b0;
        cmp    = 1'b0;
        case (op)
            4'd1:    result = a_val + b_val;
            4'd2:    result = a_val - b_val;
            4'd3:    result = a_val & b_val;
            4'd4:    result = a_val | b_val;
            4'd5:    result = a_val ^ b_val;
            4'd6:    result = a_val << b_val[4:0];
            4'd7:    result = a_val >> b_val[4:0];
            4'd8:    result = a_val * b_val;
            4'd9: begin
                cmp    = (a_val == b_val);
                is_cmp = 1'b1;
                result = DATA_W'(cmp);
            end
            4'd10: begin
                cmp    = (a_val < b_val);
                is_cmp = 1'b1;
                result = DATA_W'(cmp);
            end
            4'd11:   result = a_val;
            4'd12:   result = p ? a_val : b_val;
            default: is_nop = 1'b1;
        endcase
    end

    always_comb begin
        pred_hit = 1'b0;
        pred_val = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (psrc == 3'(k)) begin
                pred_hit = 1'b1;
                pred_val = in_pred[k];
            end
        end
        p_next = p;
        if (is_cmp) p_next = cmp;
        else if (op == 4'd11 && pred_hit) p_next = pred_val;
    end

    // A guarded context whose predicate is clear is squashed entirely.
    assign exec = (state == RUN) && !(pguard && !p);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cp    <= '0;
            pass  <= '0;
            loops <= 8'd1;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cp    <= '0;
                        pass  <= '0;
                        loops <= (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
                        len   <= len_clamped;
                        state <= (ctx_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (cp_last) begin
                        cp   <= '0;
                        pass <= pass + 8'd1;
                        if (pass == loops - 8'd1) state <= DONE;
                    end else begin
                        cp <= cp + AW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p        <= 1'b0;
            out_data <= '0;
            out_pred <= 1'b0;
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else if (exec && !is_nop) begin
            p <= p_next;
            if (wr && !is_cmp) begin
                for (int k = 0; k < NREG; k++) begin
                    if (dst == 3'(k)) regs[k] <= result;
                end
            end
            if (oe) begin
                out_data <= result;
                out_pred <= p_next;
            end
        end
    end

    // Context memory keeps its contents through reset and is frozen while running.
    always_ff @(posedge CLK) begin
        if (cfg_we && state != RUN) ctx_mem[cfg_addr] <= cfg_data[28:0];
    end

endmodule
